// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder for the MEM stage of the 5-stage pipeline.
// It accepts one word request at a time and holds the pipeline with `stall`
// for LATENCY wait cycles. It then performs the access and returns a one-cycle
// `ack`, with `ReadData` valid for loads and `err` flagging a bad request.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (power of 2)
//   LATENCY     : access latency in WAIT cycles (>= 1)
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   reset     : synchronous active-low reset
//   MemRead   : load request, held until acknowledged
//   MemWrite  : store request, held until acknowledged
//   Address   : byte address; word index is Address[log2(DEPTH_WORDS)+1:2]
//   WriteData : store data
//   ReadData  : registered load data
//   stall     : combinational pipeline hold
//   ack       : registered one-cycle completion pulse
//   err       : registered error flag, valid with ack
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        ack,
    output logic        err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;

    logic               req_read;
    logic               req_write;
    logic               req_err;
    logic [IDX_W-1:0]   req_idx;
    logic [31:0]        req_wdata;

    // Contents survive reset; they start at zero only at time 0.
    logic [31:0]        mem [DEPTH_WORDS] = '{default: '0};

    logic               accept;
    logic               access;

    // Upper address bits are deliberately ignored so addresses wrap.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^Address[31:IDX_W+2];

    assign accept = (state == S_IDLE) && (MemRead || MemWrite);
    assign access = (state == S_WAIT) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    stall      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (!reset) begin
            stall = 1'b0;
        end
    end

    // Request latch: only these copies are used once the request is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_read  <= MemRead;
            req_write <= MemWrite;
            req_err   <= (Address[1:0] != 2'b00) || (MemRead && MemWrite);
            req_idx   <= Address[IDX_W+1:2];
            req_wdata <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            ReadData <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (accept) begin
                cnt <= CNT_W'(LATENCY - 1);
            end else if ((state == S_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                ack <= 1'b1;
                err <= req_err;
                if (req_read) begin
                    ReadData <= req_err ? '0 : mem[req_idx];
                end
            end
        end
    end

    // A reset at the access edge discards the access, so the write is gated by reset.
    always_ff @(posedge clk) begin
        if (reset && access && req_write && !req_err) begin
            mem[req_idx] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Unit 0: LATENCY=2, unit 1: LATENCY=4, unit 2: LATENCY=1
    int          lat_of [3] = '{2, 4, 1};

    logic        rst_n      [3];
    logic        mem_read   [3];
    logic        mem_write  [3];
    logic [31:0] address    [3];
    logic [31:0] write_data [3];
    logic [31:0] read_data  [3];
    logic        stall      [3];
    logic        ack        [3];
    logic        err        [3];

    int          n_checks = 0;
    int          n_errors = 0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
        .Address(address[0]), .WriteData(write_data[0]), .ReadData(read_data[0]),
        .stall(stall[0]), .ack(ack[0]), .err(err[0])
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
        .Address(address[1]), .WriteData(write_data[1]), .ReadData(read_data[1]),
        .stall(stall[1]), .ack(ack[1]), .err(err[1])
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .MemRead(mem_read[2]), .MemWrite(mem_write[2]),
        .Address(address[2]), .WriteData(write_data[2]), .ReadData(read_data[2]),
        .stall(stall[2]), .ack(ack[2]), .err(err[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete request on unit u; request held until ack is seen.
    task automatic do_req(input int u, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input string tag,
                          output logic [31:0] rdata, output logic e);
        int n;
        @(posedge clk); #1;
        mem_read[u]   = rd;
        mem_write[u]  = wr;
        address[u]    = addr;
        write_data[u] = wd;
        #1;
        check({tag, "_stall_accept"}, 32'(stall[u]), 32'd1);
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
            if (!ack[u]) check({tag, "_stall_wait"}, 32'(stall[u]), 32'd1);
        end while (!ack[u] && n < 20);
        check({tag, "_ack_cycle"}, 32'(n), 32'(lat_of[u] + 1));
        check({tag, "_stall_resp"}, 32'(stall[u]), 32'd0);
        rdata = read_data[u];
        e     = err[u];
        mem_read[u]  = 1'b0;
        mem_write[u] = 1'b0;
        @(posedge clk); #2;
        check({tag, "_ack_pulse"}, 32'(ack[u]), 32'd0);
        check({tag, "_err_pulse"}, 32'(err[u]), 32'd0);
    endtask

    logic [31:0] rdata;
    logic        e;

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst_n[u]      = 1'b0;
            mem_read[u]   = 1'b0;
            mem_write[u]  = 1'b0;
            address[u]    = '0;
            write_data[u] = '0;
        end
        repeat (2) @(posedge clk);
        #2;
        for (int u = 0; u < 3; u++) begin
            check("rst_rdata", read_data[u], 32'd0);
            check("rst_ack", 32'(ack[u]), 32'd0);
            check("rst_err", 32'(err[u]), 32'd0);
            check("rst_stall", 32'(stall[u]), 32'd0);
        end
        for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;

        // ---- unit 0, LATENCY=2 ----
        do_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, "init_ld", rdata, e);
        check("init_ld_data", rdata, 32'h0);
        do_req(0, 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, "st40", rdata, e);
        check("st40_err", 32'(e), 32'd0);
        check("st40_rdata_kept", rdata, 32'h0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, "ld40", rdata, e);
        check("ld40_data", rdata, 32'hDEAD_BEEF);
        check("ld40_err", 32'(e), 32'd0);

        do_req(0, 1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, "st400", rdata, e);
        check("st400_err", 32'(e), 32'd0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0, "ld000", rdata, e);
        check("wrap_data", rdata, 32'h1234_5678);

        do_req(0, 1'b1, 1'b0, 32'h0000_0041, 32'h0, "ld41", rdata, e);
        check("ld41_err", 32'(e), 32'd1);
        check("ld41_data", rdata, 32'h0);

        do_req(0, 1'b0, 1'b1, 32'h0000_0042, 32'h0000_0055, "st42", rdata, e);
        check("st42_err", 32'(e), 32'd1);
        do_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, "ld40b", rdata, e);
        check("misalign_nowrite", rdata, 32'hDEAD_BEEF);

        do_req(0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0099, "both", rdata, e);
        check("both_err", 32'(e), 32'd1);
        do_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, "ld40c", rdata, e);
        check("both_nowrite", rdata, 32'hDEAD_BEEF);
        check("ld40c_err", 32'(e), 32'd0);

        // ---- unit 1, LATENCY=4: reset in second WAIT cycle ----
        do_req(1, 1'b0, 1'b1, 32'h0000_0080, 32'h1111_1111, "u1_st", rdata, e);
        @(posedge clk); #1;
        mem_write[1]  = 1'b1;
        address[1]    = 32'h0000_0080;
        write_data[1] = 32'hAAAA_5555;
        @(posedge clk); #1;   // first WAIT
        @(posedge clk); #1;   // second WAIT
        rst_n[1]     = 1'b0;
        mem_write[1] = 1'b0;
        #1;
        check("rstmid_stall_in_rst", 32'(stall[1]), 32'd0);
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rstmid_no_ack", 32'(ack[1]), 32'd0);
            @(posedge clk); #1;
        end
        do_req(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, "u1_ld", rdata, e);
        check("rstmid_old_value", rdata, 32'h1111_1111);

        // ---- unit 2, LATENCY=1: three loads held continuously ----
        do_req(2, 1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_0001, "u2_st", rdata, e);
        @(posedge clk); #1;
        mem_read[2] = 1'b1;
        address[2]  = 32'h0000_0000;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            #1;
            check($sformatf("b2b_stall_c%0d", c), 32'(stall[2]), 32'((c % 3) != 2));
            check($sformatf("b2b_ack_c%0d", c), 32'(ack[2]), 32'((c % 3) == 2));
            if ((c % 3) == 2) begin
                check($sformatf("b2b_data_c%0d", c), read_data[2], 32'hCAFE_0001);
                check($sformatf("b2b_err_c%0d", c), 32'(err[2]), 32'd0);
            end
        end
        mem_read[2] = 1'b0;
        @(posedge clk); #2;
        check("b2b_idle_stall", 32'(stall[2]), 32'd0);
        check("b2b_idle_ack", 32'(ack[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
